// File: rtl/map_write_arbiter_pkg.sv
// map_write_arbiter_pkg: tile-map geometry, blanking row and FSM encoding shared by the map write arbiter.
package map_write_arbiter_pkg;
    localparam int MAP_W      = 16;
    localparam int MAP_H      = 12;
    localparam int MAP_TILES  = MAP_W * MAP_H;
    localparam int ADDR_W     = 8;
    localparam int COORD_W    = 4;
    localparam int VBLANK_ROW = 480;
    typedef enum logic {S_IDLE, S_CLEAR} state_t;
endpackage

// File: rtl/map_write_arbiter_if.sv
// map_write_arbiter_if: requester, clear-control and map RAM write-port signals of the map write arbiter.
interface map_write_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 1
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*4-1:0]      req_x;
    logic [NUM_REQ*4-1:0]      req_y;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic                      clear_start;
    logic [DATA_W-1:0]         clear_value;
    logic [9:0]                row;
    logic [ADDR_W-1:0]         map_addr;
    logic [DATA_W-1:0]         map_data;
    logic                      map_we;
    logic                      busy;
    logic                      clear_done;
    logic                      oob_err;
    modport master (
        output req, req_x, req_y, req_data, clear_start, clear_value, row,
        input  ack, map_addr, map_data, map_we, busy, clear_done, oob_err
    );
    modport slave (
        input  req, req_x, req_y, req_data, clear_start, clear_value, row,
        output ack, map_addr, map_data, map_we, busy, clear_done, oob_err
    );
endinterface

// File: rtl/map_write_arbiter_rr_arbiter.sv
// map_write_arbiter_rr_arbiter: round-robin picker, first requester at or after the pointer wins.
module map_write_arbiter_rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_take,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx
);
    logic [IDX_W-1:0] r_ptr;
    function automatic logic [IDX_W-1:0] wrap(input logic [IDX_W-1:0] ptr, input int k);
        int j;
        j = int'(ptr) + k;
        return IDX_W'(j >= NUM_REQ ? j - NUM_REQ : j);
    endfunction
    // scan from farthest to nearest offset so the nearest hit is the one kept
    always_comb begin
        o_valid = 1'b0;
        o_idx   = r_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req[wrap(r_ptr, k)]) begin
                o_valid = 1'b1;
                o_idx   = wrap(r_ptr, k);
            end
        end
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_ptr <= '0;
        else if (i_take)
            r_ptr <= (o_idx == IDX_W'(NUM_REQ - 1)) ? '0 : o_idx + 1'b1;
    end
endmodule

// File: rtl/map_write_arbiter.sv
// map_write_arbiter: round-robin owner of the tile-map RAM write port with a built-in full-map clear.
// Define MAP_WRITE_VBLANK_ONLY_EN to restrict all writes to vertical blanking (row >= 480).
module map_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MAP_W   = map_write_arbiter_pkg::MAP_W,
    parameter int MAP_H   = map_write_arbiter_pkg::MAP_H,
    parameter int ADDR_W  = map_write_arbiter_pkg::ADDR_W,
    parameter int DATA_W  = 1
) (
    input logic                 clk25,
    input logic                 reset,
    map_write_arbiter_if.slave  bus
);
    import map_write_arbiter_pkg::*;
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = ADDR_W + 1;
    localparam int TILES = MAP_W * MAP_H;
    state_t              r_state, w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_fill;
    logic                r_we, r_busy, r_done, r_oob;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [NUM_REQ-1:0]  r_ack;
    logic                w_win, w_valid, w_take, w_oob, w_clear_go, w_fill_wr, w_fill_end;
    logic [IDX_W-1:0]    w_idx;
    logic [COORD_W-1:0]  w_x, w_y;
    logic [ADDR_W-1:0]   w_req_addr;
    logic                w_we, w_busy, w_done, w_oob_err;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_data;
    logic [NUM_REQ-1:0]  w_ack;
`ifdef MAP_WRITE_VBLANK_ONLY_EN
    assign w_win = int'(bus.row) >= VBLANK_ROW;
`else
    assign w_win = 1'b1;
`endif
    map_write_arbiter_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_clk   (clk25),
        .i_rst   (reset),
        .i_req   (bus.req),
        .i_take  (w_take),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );
    // clear_start outranks any pending request in the same cycle
    assign w_clear_go = (r_state == S_IDLE) && bus.clear_start;
    assign w_take     = (r_state == S_IDLE) && !bus.clear_start && w_win && w_valid;
    assign w_fill_end = (r_state == S_CLEAR) && (r_cnt == CNT_W'(TILES));
    assign w_fill_wr  = (r_state == S_CLEAR) && !w_fill_end && w_win;
    assign w_x        = bus.req_x[w_idx*COORD_W +: COORD_W];
    assign w_y        = bus.req_y[w_idx*COORD_W +: COORD_W];
    assign w_oob      = (int'(w_x) >= MAP_W) || (int'(w_y) >= MAP_H);
    assign w_req_addr = ADDR_W'(w_y) * ADDR_W'(MAP_W) + ADDR_W'(w_x);
    always_ff @(posedge clk25 or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end
    always_comb begin
        w_next = w_clear_go ? S_CLEAR : w_fill_end ? S_IDLE : r_state;
    end
    always_comb begin
        w_we         = w_fill_wr || (w_take && !w_oob);
        w_addr       = w_fill_wr ? r_cnt[ADDR_W-1:0] : w_we ? w_req_addr : '0;
        w_data       = w_fill_wr ? r_fill : w_we ? bus.req_data[w_idx*DATA_W +: DATA_W] : '0;
        w_ack        = '0;
        w_ack[w_idx] = w_take;
        w_oob_err    = w_take && w_oob;
        w_done       = w_fill_end;
        w_busy       = (w_next == S_CLEAR);
    end
    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_fill <= '0;
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_ack  <= '0;
            r_oob  <= 1'b0;
            r_done <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_cnt  <= w_clear_go ? '0 : w_fill_wr ? r_cnt + 1'b1 : r_cnt;
            r_fill <= w_clear_go ? bus.clear_value : r_fill;
            r_we   <= w_we;
            r_addr <= w_addr;
            r_data <= w_data;
            r_ack  <= w_ack;
            r_oob  <= w_oob_err;
            r_done <= w_done;
            r_busy <= w_busy;
        end
    end
    assign bus.map_we     = r_we;
    assign bus.map_addr   = r_addr;
    assign bus.map_data   = r_data;
    assign bus.ack        = r_ack;
    assign bus.oob_err    = r_oob;
    assign bus.clear_done = r_done;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_map_write_arbiter.sv
// tb_map_write_arbiter: directed scoreboard bench for map_write_arbiter in its default (always-writable) build.
module tb_map_write_arbiter;
    typedef struct packed {
        logic [3:0] ack;
        logic       we;
        logic [7:0] addr;
        logic       data;
        logic       oob;
        logic       done;
        logic       busy;
    } obs_t;
    logic clk25 = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    obs_t sb[$];
    obs_t idle;
    map_write_arbiter_if #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(1)) bus();
    map_write_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(1)) dut (
        .clk25 (clk25),
        .reset (reset),
        .bus   (bus)
    );
    always #20 clk25 = ~clk25;
    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog expired");
    end
    function automatic obs_t mk(logic [3:0] ack, logic we, int addr, logic data,
                                logic oob, logic done, logic busy);
        obs_t o;
        o.ack  = ack;
        o.we   = we;
        o.addr = 8'(addr);
        o.data = data;
        o.oob  = oob;
        o.done = done;
        o.busy = busy;
        return o;
    endfunction
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    task automatic cmp(input string tag, input obs_t e);
        chk({tag, ".ack"},  8'(bus.ack),        8'(e.ack));
        chk({tag, ".we"},   8'(bus.map_we),     8'(e.we));
        chk({tag, ".oob"},  8'(bus.oob_err),    8'(e.oob));
        chk({tag, ".done"}, 8'(bus.clear_done), 8'(e.done));
        chk({tag, ".busy"}, 8'(bus.busy),       8'(e.busy));
        if (e.we) begin
            chk({tag, ".addr"}, bus.map_addr,      e.addr);
            chk({tag, ".data"}, 8'(bus.map_data),  8'(e.data));
        end
    endtask
    task automatic tick(input string tag);
        @(posedge clk25);
        #1;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s scoreboard got empty exp entry", tag);
        end
        if (sb.size() != 0) cmp(tag, sb.pop_front());
    endtask
    task automatic set_slice(input int i, input logic [3:0] x, input logic [3:0] y, input logic d);
        bus.req_x[i*4 +: 4] = x;
        bus.req_y[i*4 +: 4] = y;
        bus.req_data[i]     = d;
    endtask
    initial begin
        idle = mk(4'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.req = '0;
        bus.req_x = '0;
        bus.req_y = '0;
        bus.req_data = '0;
        bus.clear_start = 1'b0;
        bus.clear_value = 1'b0;
        bus.row = '0;
        sb.push_back(idle); tick("reset0");
        chk("reset0.addr", bus.map_addr, 8'h00);
        chk("reset0.data", 8'(bus.map_data), 8'h00);
        sb.push_back(idle); tick("reset1");
        reset = 1'b0;
        sb.push_back(idle); tick("post_reset");
        for (int i = 0; i < 4; i++) set_slice(i, 4'(i + 1), 4'(i + 2), i[0]);
        bus.req = 4'hf;
        for (int k = 0; k < 8; k++) begin
            int g;
            g = k % 4;
            sb.push_back(mk(4'(1 << g), 1'b1, (g + 2) * 16 + g + 1, g[0], 1'b0, 1'b0, 1'b0));
            tick($sformatf("fair%0d", k));
        end
        bus.req = '0;
        sb.push_back(idle); tick("fair_end");
        set_slice(1, 4'd3, 4'd2, 1'b1);
        bus.req = 4'b0010;
        sb.push_back(mk(4'b0010, 1'b1, 35, 1'b1, 1'b0, 1'b0, 1'b0)); tick("single");
        bus.req = '0;
        sb.push_back(idle); tick("single_end");
        set_slice(0, 4'd5, 4'd12, 1'b1);
        bus.req = 4'b0001;
        sb.push_back(mk(4'b0001, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0)); tick("oob");
        set_slice(1, 4'd15, 4'd11, 1'b1);
        bus.req = 4'b0010;
        sb.push_back(mk(4'b0010, 1'b1, 191, 1'b1, 1'b0, 1'b0, 1'b0)); tick("after_oob");
        bus.req = '0;
        sb.push_back(idle); tick("oob_end");
        set_slice(2, 4'd7, 4'd3, 1'b1);
        bus.req = 4'b0100;
        bus.clear_start = 1'b1;
        bus.clear_value = 1'b0;
        sb.push_back(mk(4'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1)); tick("clr_start");
        for (int a = 0; a < 192; a++) begin
            bus.clear_start = (a == 50);
            if (a == 50) bus.clear_value = 1'b1;
            sb.push_back(mk(4'h0, 1'b1, a, 1'b0, 1'b0, 1'b0, 1'b1));
            tick($sformatf("clr%0d", a));
        end
        sb.push_back(mk(4'h0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0)); tick("clr_done");
        sb.push_back(mk(4'b0100, 1'b1, 55, 1'b1, 1'b0, 1'b0, 1'b0)); tick("clr_req2");
        bus.req = '0;
        sb.push_back(idle); tick("clr_end");
        bus.clear_start = 1'b1;
        bus.clear_value = 1'b1;
        sb.push_back(mk(4'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1)); tick("rclr_start");
        bus.clear_start = 1'b0;
        for (int a = 0; a < 100; a++) begin
            sb.push_back(mk(4'h0, 1'b1, a, 1'b1, 1'b0, 1'b0, 1'b1));
            tick($sformatf("rclr%0d", a));
        end
        reset = 1'b1;
        #1;
        cmp("async_reset", idle);
        chk("async_reset.addr", bus.map_addr, 8'h00);
        chk("async_reset.data", 8'(bus.map_data), 8'h00);
        sb.push_back(idle); tick("rst_hold");
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sb.push_back(idle);
            tick($sformatf("post_rst%0d", k));
        end
        set_slice(0, 4'd4, 4'd1, 1'b0);
        set_slice(3, 4'd0, 4'd0, 1'b1);
        bus.req = 4'b1001;
        sb.push_back(mk(4'b0001, 1'b1, 20, 1'b0, 1'b0, 1'b0, 1'b0)); tick("ptr_reset");
        bus.req = 4'b1000;
        sb.push_back(mk(4'b1000, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0)); tick("req3");
        bus.req = '0;
        sb.push_back(idle); tick("final_idle");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
